// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins); default is round-robin.
module alu_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_op,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_op,

    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_cntr,
    input  logic [N-1:0] alu_r,
    input  logic [3:0]   alu_flags,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_r,
    output logic [3:0]   rsp_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   grant_any;
    logic   grant_id;
    logic   accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = ~req0_valid;
    end
`else
    logic rr_ptr;  // preferred requester when both are valid

    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = rr_ptr;
        end else begin
            grant_id = req1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant_id;
        end
    end
`endif

    // NOTE: every signal driven here gets a default before the case; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst && grant_any) begin
                    state_nxt  = EXEC;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = ~rst;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = req0_ready | req1_ready;

    // NOTE: reset is synchronous: rst is sampled at the clock edge inside the block,
    // so it does not appear in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cntr  <= '0;
            rsp_id    <= 1'b0;
            rsp_r     <= '0;
            rsp_flags <= '0;
        end else begin
            if (accept) begin
                alu_a    <= grant_id ? req1_a  : req0_a;
                alu_b    <= grant_id ? req1_b  : req0_b;
                alu_cntr <= grant_id ? req1_op : req0_op;
                rsp_id   <= grant_id;
            end
            // The ALU output settles from the registered operands during EXEC.
            if (state == EXEC) begin
                rsp_r     <= alu_r;
                rsp_flags <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: reference ALU, transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic [N-1:0] alu_a, alu_b, alu_r;
    logic [2:0]   alu_cntr;
    logic [3:0]   alu_flags;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_r;
    logic [3:0]   rsp_flags;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntr(alu_cntr),
        .alu_r(alu_r), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_flags(rsp_flags)
    );

    // Reference ALU: flags are {N, Z, C, V}; C is carry-out for add, no-borrow for sub.
    typedef struct packed {
        logic [N-1:0] r;
        logic [3:0]   f;
    } alu_out_t;

    function automatic alu_out_t ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] op);
        alu_out_t   o;
        logic [N:0] w;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: begin
                w = {1'b0, a} + {1'b0, b};
                c = w[N];
                v = (a[N-1] == b[N-1]) && (w[N-1] != a[N-1]);
            end
            3'b001: begin
                w = {1'b0, a} - {1'b0, b};
                c = ~w[N];
                v = (a[N-1] != b[N-1]) && (w[N-1] != a[N-1]);
            end
            3'b010:  w = {1'b0, a & b};
            3'b011:  w = {1'b0, a | b};
            3'b100:  w = {1'b0, a ^ b};
            3'b101:  w = {1'b0, ~a};
            default: w = {1'b0, a};
        endcase
        o.r = w[N-1:0];
        o.f = {o.r[N-1], (o.r == '0), c, v};
        return o;
    endfunction

    alu_out_t alu_o;
    assign alu_o     = ref_alu(alu_a, alu_b, alu_cntr);
    assign alu_r     = alu_o.r;
    assign alu_flags = alu_o.f;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one operation in flight at most; the response becomes
    // visible two cycles after the cycle it was accepted in and stays until consumed.
    typedef struct {
        logic         id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
    } txn_t;

    initial begin : compare
        bit           synced;
        bit           busy;
        bit           pref;
        bit           g_any;
        bit           g_id;
        bit           exp_v;
        logic [1:0]   want;
        int           cyc;
        int           acc_cyc;
        txn_t         cur;
        logic [N-1:0] m_a;
        logic [N-1:0] m_b;
        logic [2:0]   m_op;
        alu_out_t     exp_o;
        synced = 0; busy = 0; pref = 0; cyc = 0; acc_cyc = 0;
        m_a = '0; m_b = '0; m_op = '0;
        cur = '{id: 1'b0, a: '0, b: '0, op: '0};
        forever begin
            @(negedge clk);
            exp_v = !rst && busy && (cyc >= acc_cyc + 2);
            want  = {req1_valid, req0_valid};
            g_any = want != 2'b00;
            g_id  = want[pref] ? pref : !pref;
            if (synced) begin
                check("req0_ready", req0_ready, !rst && !busy && g_any && !g_id);
                check("req1_ready", req1_ready, !rst && !busy && g_any && g_id);
                check("rsp_valid", rsp_valid, exp_v);
                check("alu_a", alu_a, m_a);
                check("alu_b", alu_b, m_b);
                check("alu_cntr", alu_cntr, m_op);
                if (exp_v) begin
                    exp_o = ref_alu(cur.a, cur.b, cur.op);
                    check("rsp_id", rsp_id, cur.id);
                    check("rsp_r", rsp_r, exp_o.r);
                    check("rsp_flags", rsp_flags, exp_o.f);
                end
                if (rsp_valid && rsp_ready) n_done++;
            end
            if (rst) begin
                synced = 1; busy = 0; pref = 0;
                m_a = '0; m_b = '0; m_op = '0;
            end else if (!busy && g_any) begin
                busy    = 1;
                acc_cyc = cyc;
                cur.id  = g_id;
                cur.a   = g_id ? req1_a  : req0_a;
                cur.b   = g_id ? req1_b  : req0_b;
                cur.op  = g_id ? req1_op : req0_op;
                m_a = cur.a; m_b = cur.b; m_op = cur.op;
`ifndef ALU_ARB_FIXED_PRIO_EN
                pref = !g_id;
`endif
            end else if (exp_v && rsp_ready) begin
                busy = 0;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        bit   seen;
        int   ng;
        int   nr;
        int   n1;
        logic gid [4];
        int   gcyc [4];
        logic rid [4];
        logic last_id;
        logic exp_id;

        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h0f; req0_op = 3'b011;
        req1_valid = 1'b1; req1_a = 8'h12; req1_b = 8'h34; req1_op = 3'b000;
        repeat (3) tick();

        // Reset holds everything at zero even with requests pending.
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_cntr", alu_cntr, 0);
        check("rst_rsp_r", rsp_r, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_id", rsp_id, 0);

        tick(); rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        tick();

        // Single request: 15 + 10.
        req0_valid = 1'b1; req0_a = 8'd15; req0_b = 8'd10; req0_op = 3'b000;
        @(negedge clk);
        check("single_req0_ready", req0_ready, 1);
        check("single_req1_ready", req1_ready, 0);
        tick(); req0_valid = 1'b0;
        @(negedge clk);
        check("single_exec_rsp_valid", rsp_valid, 0);
        tick();
        @(negedge clk);
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_id", rsp_id, 0);
        check("single_rsp_r", rsp_r, 8'd25);
        check("single_rsp_flags", rsp_flags, 4'b0000);
        tick();
        @(negedge clk);
        check("single_after_rsp_valid", rsp_valid, 0);

        // Backpressure: -120 - 88 wraps to 48 with C and V set; req0 waits meanwhile.
        tick(); req1_valid = 1'b1; req1_a = 8'h88; req1_b = 8'd88; req1_op = 3'b001; rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_req1_ready", req1_ready, 1);
        tick(); req1_valid = 1'b0; req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_op = 3'b000;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_id", rsp_id, 1);
            check("bp_rsp_r", rsp_r, 8'd48);
            check("bp_rsp_flags", rsp_flags, 4'b0011);
            check("bp_no_accept", req0_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", rsp_valid, 1);
        tick();
        @(negedge clk);
        check("bp_idle_rsp_valid", rsp_valid, 0);
        check("bp_idle_req0_ready", req0_ready, 1);
        tick(); req0_valid = 1'b0;
        repeat (3) tick();

        // Reset while a response is being held.
        rsp_ready = 1'b0; req1_valid = 1'b1; req1_a = 8'h7f; req1_b = 8'h01; req1_op = 3'b000;
        tick(); req1_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        check("mid_resp_reached", seen, 1);
        tick(); rst = 1'b1;
        @(negedge clk);
        check("mid_resp_rst_valid", rsp_valid, 0);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_alu_a", alu_a, 0);
        check("post_rst_alu_b", alu_b, 0);
        check("post_rst_rsp_r", rsp_r, 0);
        check("post_rst_rsp_flags", rsp_flags, 0);
        check("post_rst_rsp_id", rsp_id, 0);

        // Contention with both requesters continuously valid.
        tick(); rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'd100; req0_b = 8'd27; req0_op = 3'b100;
        req1_valid = 1'b1; req1_a = 8'd200; req1_b = 8'd100; req1_op = 3'b000;
        ng = 0; nr = 0; n1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req1_ready) n1++;
            if (req0_ready || req1_ready) begin
                if (ng < 4) begin
                    gid[ng]  = req1_ready;
                    gcyc[ng] = i;
                end
                ng++;
            end
            if (rsp_valid && rsp_ready && nr < 4) begin
                rid[nr] = rsp_id;
                nr++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("cont_grant_count", ng, 4);
        check("cont_rsp_count", nr, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = k[0];
`endif
            check("cont_grant_id", gid[k], exp_id);
            check("cont_grant_cycle", gcyc[k], 3 * k);
            check("cont_rsp_id", rid[k], exp_id);
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        check("cont_req1_never_ready", n1, 0);
`else
        check("cont_req1_ready_count", n1, 2);
`endif

        // Withdrawn request: req1 pulses valid only while req0 is executing.
        tick(); req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd6; req0_op = 3'b010;
        @(negedge clk);
        check("wd_req0_ready", req0_ready, 1);
        tick(); req0_valid = 1'b0; req1_valid = 1'b1;
        tick(); req1_valid = 1'b0;
        nr = 0; last_id = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                nr++;
                last_id = rsp_id;
            end
            tick();
        end
        check("wd_rsp_count", nr, 1);
        check("wd_rsp_id", last_id, 0);

        // Randomized traffic with occasional resets and backpressure.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst        = ($urandom_range(0, 199) == 0);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a     = N'($urandom);
            req0_b     = N'($urandom);
            req0_op    = 3'($urandom);
            req1_a     = N'($urandom);
            req1_b     = N'($urandom);
            req1_op    = 3'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
        end
        tick(); rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (5) tick();
        check("random_traffic_seen", (n_done > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 8, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester k presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  requester k's operation is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  N each  signed operands.
REQ-007 req0_op / req1_op  input  3 each  ALU operation code, passed unmodified to Cntr.
REQ-008 alu_a, alu_b  output  N each  registered operands to the shared ALU.
REQ-009 alu_cntr  output  3  registered operation code to the shared ALU.
REQ-010 alu_r  input  N  ALU result, combinational from alu_a/alu_b/alu_cntr.
REQ-011 alu_flags  input  4  ALU flags {N,Z,C,V}.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  1  index of the requester that owns the response.
REQ-015 rsp_r  output  N  captured result; rsp_flags  output  4  captured flags.

Function
REQ-016 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-017 IDLE: grant computed combinationally from valid inputs; reqk_ready = (state==IDLE) && grant==k; at most one ready high per cycle.
REQ-018 IDLE with no valid request: stay IDLE, both readies low, ALU registers hold.
REQ-019 IDLE with accepted request (valid&&ready): latch that requester's a, b, op into alu_a/alu_b/alu_cntr, latch id, go EXEC.
REQ-020 EXEC (exactly 1 cycle): capture alu_r into rsp_r, alu_flags into rsp_flags; go RESP.
REQ-021 RESP: rsp_valid high; hold rsp_id/rsp_r/rsp_flags stable until rsp_valid&&rsp_ready; on that edge go IDLE.
REQ-022 rsp_valid is high only in RESP; readies are low in EXEC and RESP.
REQ-023 Latency: acceptance at edge T, rsp_valid high from T+2; back-to-back throughput one operation per 3 cycles with rsp_ready held high.
REQ-024 Round-robin (default): 1-bit pointer names the preferred requester; if both valid, preferred wins; if one valid, it wins; after each acceptance pointer = NOT(granted id); pointer resets to 0.
REQ-025 Requester dropping valid while not ready has no effect; no operation is lost or duplicated.
REQ-026 Operands and results pass through unchanged in width (N bits); block performs no arithmetic.

Reset
REQ-027 rst high at any edge, in any state, forces: state IDLE, pointer 0, alu_a=0, alu_b=0, alu_cntr=0, rsp_r=0, rsp_flags=0, rsp_id=0.
REQ-028 Operation in EXEC or RESP at reset is discarded; no response is issued for it.
REQ-029 While rst is high, req0_ready, req1_ready and rsp_valid are 0.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins contention and the round-robin pointer is not implemented.
REQ-031 When ALU_ARB_FIXED_PRIO_EN is undefined, arbitration follows REQ-024.

Verification
REQ-032 Reset mid-RESP: rst for one cycle -> next cycle rsp_valid=0, all registered outputs 0, state IDLE.
REQ-033 Single request: req0 a=15, b=10, op=3'b000, rsp_ready=1 -> req0_ready same cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_r/rsp_flags equal to ALU output for 15,10,000 (25, flags 0000 with reference ALU add).
REQ-034 Contention round-robin: both valid continuously, rsp_ready=1 -> grants 0,1,0,1 at 3-cycle spacing; rsp_id sequence 0,1,0,1.
REQ-035 Contention with ALU_ARB_FIXED_PRIO_EN defined: both valid continuously -> every grant to requester 0; req1_ready never high.
REQ-036 Backpressure: req1 a=-120, b=88, op=3'b001, rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_r/rsp_flags/rsp_id=1 stable, no new acceptance; rsp_ready=1 -> IDLE next cycle.
REQ-037 Withdrawn request: req1_valid high then low during EXEC of req0 -> only req0 response issued; no response for req1.
